// File: rtl/sig_pkg.sv
// Shared constants, state encoding and bit-packing helper for the signature serializer.
package sig_pkg;

    localparam int unsigned SIG_W     = 9800;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_WORDS = (SIG_W + WORD_W - 1) / WORD_W;
    // Shadow is padded to a whole number of words; pad bits are always zero.
    localparam int unsigned PAD_W     = NUM_WORDS * WORD_W;
    localparam int unsigned IDX_W     = 9;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StTrail
    } state_e;

    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    // The lowest-numbered signature bit of a word goes out on the word's MSB.
    function automatic logic [WORD_W-1:0] pack_word(input logic [WORD_W-1:0] bits);
        logic [WORD_W-1:0] w;
        for (int i = 0; i < int'(WORD_W); i++) begin
            w[WORD_W-1-i] = bits[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/sig_crc32_word.sv
// Combinational CRC-32 update over one 32-bit word, MSB first, no reflection.
module sig_crc32_word
    import sig_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    output logic [31:0] crc_out
);

    logic [31:0] crc;

    // Unrolled bit-serial LFSR step, data bit 31 first.
    always_comb begin
        crc = crc_in;
        for (int i = 31; i >= 0; i--) begin
            if (crc[31] ^ data[i]) begin
                crc = {crc[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                crc = {crc[30:0], 1'b0};
            end
        end
        crc_out = crc;
    end

endmodule

// File: rtl/sig_serializer.sv
// Captures a finished signature into a shadow register and streams it out as words over a
// valid/ready handshake. Define SIGSER_CRC_EN to append a CRC-32 trailer word after the data.
module sig_serializer
    import sig_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIG_W-1:0]  sig,
    input  logic              sig_valid,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W-1:0]  word_idx
);

    state_e              state_q, state_d;
    logic [PAD_W-1:0]    shadow_q, shadow_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [WORD_W-1:0]   dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                dout_last_q, dout_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic xfer;
    logic last_data;

    assign xfer      = dout_valid_q & dout_ready;
    assign last_data = (word_idx_q == LAST_IDX);

`ifdef SIGSER_CRC_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_next;

    if (WORD_W != 32) begin : g_word_w_check
        $error("sig_serializer: CRC trailer requires WORD_W == 32");
    end

    // CRC covers each data word exactly as it sits on dout, padding included.
    sig_crc32_word u_crc (
        .crc_in  (crc_q),
        .data    (dout_q),
        .crc_out (crc_next)
    );
`endif

    // Next-state and next-output computation for the capture/stream FSM.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        word_idx_d   = word_idx_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
`ifdef SIGSER_CRC_EN
        crc_d        = crc_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (sig_valid) begin
                        shadow_d     = PAD_W'(sig);
                        dout_d       = pack_word(sig[WORD_W-1:0]);
                        word_idx_d   = '0;
                        dout_valid_d = 1'b1;
                        busy_d       = 1'b1;
                        state_d      = StStream;
`ifdef SIGSER_CRC_EN
                        dout_last_d  = 1'b0;
                        crc_d        = CRC32_INIT;
`else
                        dout_last_d  = (LAST_IDX == '0);
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StStream: begin
                if (xfer) begin
                    if (!last_data) begin
                        // Shadow shifts down one word per transfer; next word is bits [63:32].
                        shadow_d   = shadow_q >> WORD_W;
                        dout_d     = pack_word(shadow_q[2*WORD_W-1 -: WORD_W]);
                        word_idx_d = word_idx_q + IDX_W'(1);
`ifdef SIGSER_CRC_EN
                        crc_d       = crc_next;
                        dout_last_d = 1'b0;
`else
                        dout_last_d = ((word_idx_q + IDX_W'(1)) == LAST_IDX);
`endif
                    end else begin
`ifdef SIGSER_CRC_EN
                        crc_d       = crc_next;
                        dout_d      = crc_next ^ CRC32_XOROUT;
                        word_idx_d  = word_idx_q + IDX_W'(1);
                        dout_last_d = 1'b1;
                        state_d     = StTrail;
`else
                        state_d      = StIdle;
                        dout_d       = '0;
                        dout_valid_d = 1'b0;
                        dout_last_d  = 1'b0;
                        word_idx_d   = '0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
`endif
                    end
                end
            end

`ifdef SIGSER_CRC_EN
            StTrail: begin
                if (xfer) begin
                    state_d      = StIdle;
                    dout_d       = '0;
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                    word_idx_d   = '0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                end
            end
`endif

            default: begin
                state_d      = StIdle;
                dout_valid_d = 1'b0;
                dout_last_d  = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            shadow_q     <= '0;
            word_idx_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef SIGSER_CRC_EN
            crc_q        <= CRC32_INIT;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            word_idx_q   <= word_idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef SIGSER_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_idx   = word_idx_q;

endmodule

// File: tb/tb_sig_serializer.sv
// Scoreboard bench for sig_serializer: frames are modelled as word lists, a monitor pops and
// compares on every handshake. Honours SIGSER_CRC_EN for the trailer word.
module tb_sig_serializer;
    import sig_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic [SIG_W-1:0]  sig;
    logic              sig_valid;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDX_W-1:0]  word_idx;

    sig_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sig        (sig),
        .sig_valid  (sig_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_idx   (word_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   errors      = 0;
    int   frames_done = 0;
    int   rdy_mode    = 0;
    int   rdy_cnt     = 0;

    task automatic check(input string name, input bit ok, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: word k holds bits k*32 .. k*32+31 of the signature, first bit on the MSB.
    function automatic logic [31:0] ref_word(input logic [SIG_W-1:0] s, input int k);
        logic [31:0] w;
        for (int j = 0; j < 32; j++) begin
            int b;
            b = k * 32 + j;
            w[31-j] = (b < int'(SIG_W)) ? s[b] : 1'b0;
        end
        return w;
    endfunction

    // Reference CRC-32: plain bitwise division over the transmitted bit stream, MSB first.
    function automatic logic [31:0] ref_crc(input logic [SIG_W-1:0] s);
        logic [31:0] c;
        logic [31:0] w;
        c = 32'hFFFF_FFFF;
        for (int k = 0; k < int'(NUM_WORDS); k++) begin
            w = ref_word(s, k);
            for (int j = 31; j >= 0; j--) begin
                logic fb;
                fb = c[31] ^ w[j];
                c = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        return c ^ 32'hFFFF_FFFF;
    endfunction

    function automatic logic [SIG_W-1:0] rand_sig();
        logic [SIG_W-1:0] s;
        for (int i = 0; i < int'(SIG_W); i++) s[i] = 1'($urandom_range(1, 0));
        return s;
    endfunction

    task automatic push_frame(input logic [SIG_W-1:0] s);
        exp_t e;
        for (int k = 0; k < int'(NUM_WORDS); k++) begin
            e.data = ref_word(s, k);
            e.idx  = k;
`ifdef SIGSER_CRC_EN
            e.last = 1'b0;
`else
            e.last = (k == int'(NUM_WORDS) - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef SIGSER_CRC_EN
        e.data = ref_crc(s);
        e.idx  = int'(NUM_WORDS);
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    // Called at posedge+2; holds start for exactly one sampling edge.
    task automatic drive_start(input logic [SIG_W-1:0] s, input logic v);
        sig       = s;
        sig_valid = v;
        start     = 1'b1;
        @(posedge clk);
        #2;
        start     = 1'b0;
        sig_valid = 1'b0;
    endtask

    // Returns at posedge+2 of the done cycle, so a following start is back-to-back.
    task automatic wait_done(input string name, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 4000) begin
            @(posedge clk);
            #2;
            cycles++;
        end
        check(name, done === 1'b1, 64'(cycles), 64'(4000));
        check({name, "_drained"}, exp_q.size() == 0, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_idx(input int target);
        int k;
        k = 0;
        while (!(dout_valid === 1'b1 && int'(word_idx) == target) && k < 4000) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("reach_idx", int'(word_idx) == target, 64'(word_idx), 64'(target));
    endtask

    task automatic run_frame(input logic [SIG_W-1:0] s, input string name, output int cycles);
        push_frame(s);
        drive_start(s, 1'b1);
        wait_done(name, cycles);
    endtask

    // Ready patterns: always high, 1,0,0,1 repeating, or random.
    always @(posedge clk) begin
        #1;
        rdy_cnt++;
        case (rdy_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ((rdy_cnt % 4) == 0) || ((rdy_cnt % 4) == 3);
            default: dout_ready = 1'($urandom_range(1, 0));
        endcase
    end

    // Monitor: compare handshakes against the scoreboard, stall stability and done timing.
    logic        prev_stall  = 1'b0;
    logic        expect_done = 1'b0;
    logic [31:0] prev_dout;
    logic        prev_last;
    logic [8:0]  prev_idx;

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            prev_stall  = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done) begin
                check("done_pulse", done === 1'b1 && busy === 1'b0, 64'({done, busy}),
                      64'(2'b10));
                expect_done = 1'b0;
                frames_done++;
            end else if (done !== 1'b0) begin
                check("stray_done", 1'b0, 64'(done), 64'(0));
            end
            if (prev_stall) begin
                check("stall_hold", dout_valid === 1'b1 && dout === prev_dout &&
                      dout_last === prev_last && word_idx === prev_idx,
                      64'({dout_valid, word_idx, dout}), 64'({1'b1, prev_idx, prev_dout}));
            end
            if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1'b0, 64'(dout), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", dout === e.data, 64'(dout), 64'(e.data));
                    check("word_last", dout_last === e.last, 64'(dout_last), 64'(e.last));
                    check("word_idx", int'(word_idx) == e.idx, 64'(word_idx), 64'(e.idx));
                    if (e.last) expect_done = 1'b1;
                end
            end
            prev_stall = (dout_valid === 1'b1) && (dout_ready === 1'b0);
            prev_dout  = dout;
            prev_last  = dout_last;
            prev_idx   = word_idx;
        end
    end

    initial begin
        logic [SIG_W-1:0] s;
        logic [SIG_W-1:0] s2;
        int cyc;
        int fsave;

        rst        = 1'b1;
        start      = 1'b0;
        sig_valid  = 1'b0;
        sig        = '0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {dout, dout_valid, dout_last, busy, done, err, word_idx} == '0,
              64'({dout, dout_valid, dout_last, busy, done, err, word_idx}), 64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Single bit 0: first word MSB, nothing else; timing of the full frame.
        rdy_mode = 0;
        s = '0;
        s[0] = 1'b1;
        run_frame(s, "frame_bit0", cyc);
`ifdef SIGSER_CRC_EN
        check("frame_cycles", cyc == int'(NUM_WORDS) + 1, 64'(cyc), 64'(NUM_WORDS + 1));
`else
        check("frame_cycles", cyc == int'(NUM_WORDS), 64'(cyc), 64'(NUM_WORDS));
`endif

        // Last eight signature bits land in the top byte of the final word (back-to-back start).
        s = '0;
        for (int i = 9792; i < 9800; i++) s[i] = 1'b1;
        run_frame(s, "frame_tail", cyc);

        // Backpressure with 1,0,0,1 ready pattern.
        rdy_mode = 1;
        run_frame(rand_sig(), "frame_bp", cyc);
        rdy_mode = 0;
        @(posedge clk);
        #2;

        // start without a valid signature raises err only.
        drive_start(rand_sig(), 1'b0);
        check("err_pulse", err === 1'b1 && dout_valid === 1'b0 && busy === 1'b0,
              64'({err, dout_valid, busy}), 64'(3'b100));
        @(posedge clk);
        #2;
        check("err_clears", err === 1'b0 && dout_valid === 1'b0 && busy === 1'b0,
              64'({err, dout_valid, busy}), 64'(0));

        // A start mid-stream must not disturb the frame in flight.
        s  = rand_sig();
        s2 = ~s;
        push_frame(s);
        drive_start(s, 1'b1);
        wait_idx(50);
        drive_start(s2, 1'b1);
        wait_done("frame_ignore_start", cyc);

        // Asynchronous reset mid-frame, then a clean restart.
        rdy_mode = 2;
        s = rand_sig();
        push_frame(s);
        drive_start(s, 1'b1);
        wait_idx(100);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", {dout, dout_valid, dout_last, busy, done, err, word_idx} == '0,
              64'({dout, dout_valid, dout_last, busy, done, err, word_idx}), 64'(0));
        exp_q.delete();
        fsave = frames_done;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("no_done_after_reset", frames_done == fsave && dout_valid === 1'b0,
              64'(frames_done), 64'(fsave));
        run_frame(rand_sig(), "frame_after_reset", cyc);
        rdy_mode = 0;
        run_frame(rand_sig(), "frame_random", cyc);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sig_serializer.md
Name: sig_serializer

Overview:
- Downstream stage of the signature generator.
- Captures the finished 9800-bit LDGM signature and streams it out as fixed-width words over a valid/ready handshake to the host/UART/bus bridge.
- Frees the generator for the next message as soon as capture completes, and flags an all-zero (invalid) signature instead of emitting it.

Parameters:
- SIG_W, 9800: signature width in bits; bit 0 is the first bit transmitted.
- WORD_W, 32: output word width.
- NUM_WORDS, ceil(SIG_W/WORD_W) = 307: data words per signature (derived, not overridable).

Ports:
- clk  in  1: system clock.
- rst  in  1: reset, asynchronous, active-high.
- start  in  1: capture request; pulse together with the generator's done.
- sig  in  SIG_W: signature bus, index 0 is the MSB-first bit.
- sig_valid  in  1: generator's nonzero flag.
- dout  out  WORD_W: output word.
- dout_valid  out  1: dout holds a word.
- dout_ready  in  1: sink accepts the word.
- dout_last  out  1: final word of the frame.
- busy  out  1: frame in progress.
- done  out  1: one-cycle pulse after the last handshake.
- err  out  1: one-cycle pulse, start seen with sig_valid=0.
- word_idx  out  9: index of the current word.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. Reset forces state IDLE and clears shadow register, word_idx, dout, dout_valid, dout_last, busy, done and err to 0.
- States: IDLE, STREAM, TRAIL (TRAIL exists only with the optional feature).
- IDLE, start=1, sig_valid=1: latch sig into the shadow register; word_idx<=0; go to STREAM. dout_valid=1 from the next cycle (1-cycle latency).
- IDLE, start=1, sig_valid=0: err=1 for one cycle; no capture; stay in IDLE.
- start in STREAM/TRAIL: ignored; the shadow register is not modified.
- Word packing: word k = shadow[k*WORD_W +: WORD_W], with shadow bit k*WORD_W placed on dout[WORD_W-1].
- Last word: word 306 carries sig[9792:9799] in dout[31:24]; dout[23:0]=0.
- Handshake: transfer occurs on a clock edge where dout_valid&dout_ready=1. While dout_valid=1 and dout_ready=0, dout, dout_last and word_idx must hold stable. dout_valid never drops without a transfer. One word per cycle when ready is held high.
- dout_last=1 exactly while word NUM_WORDS-1 is presented (or the trailer word, with the optional feature).
- Frame end: on the last transfer, go to IDLE; done=1 in the following cycle; busy=0 in that same cycle.
- Back-to-back frames: start sampled in the done cycle is accepted. Total frame with ready=1 is 307 cycles plus the done cycle.
- busy=1 in STREAM/TRAIL.
- word_idx counts 0..306 (307 with the trailer). It must never wrap within a frame.
- Reset mid-frame: immediate abort, no done, partial frame discarded; the sink must tolerate a truncated frame.

Optional Feature:
- Macro SIGSER_CRC_EN.
- Defined:
  - After data word 306, state TRAIL emits one extra word (word_idx=307) carrying CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, MSB-first, final XOR 0xFFFFFFFF) over the 307 data words exactly as transmitted, padding included.
  - dout_last moves to the trailer. The CRC register updates only on data-word transfers.
  - WORD_W must equal 32; elaboration fails otherwise.
- Undefined: no TRAIL state and no CRC logic; frame is 307 words.

Decomposition:
- Package sig_pkg: SIG_W, WORD_W, NUM_WORDS, word-index width, state enum (IDLE/STREAM/TRAIL), CRC32_POLY, CRC32_INIT, CRC32_XOROUT.
- One natural sub-module: sig_crc32_word, a combinational 32-bit-per-step CRC update (crc_in, data → crc_out), instantiated only under SIGSER_CRC_EN.

Test Plan:
1. sig has only bit 0 set, sig_valid=1, start pulse, ready=1 → 307 words. word0=0x80000000, words 1..306=0, dout_last on word 306, done one cycle later, busy low in the done cycle.
2. sig bits 9792..9799=1, others 0 → word 306 = 0xFF000000 with dout_last=1. Word 305 = 0.
3. Backpressure: ready pattern 1,0,0,1 repeating on a random sig → every word appears exactly once in order, dout stable during stalls, no dropped or duplicated word.
4. start with sig_valid=0 → err one cycle, dout_valid stays 0, busy stays 0. Then start mid-stream at word 50 with a different sig → ignored, remaining words from the original sig.
5. rst asserted for 1 cycle at word_idx=100 → all outputs 0 asynchronously, no done. A new start restarts at word0 with correct data.
6. SIGSER_CRC_EN, random sig → 308 words. Trailer matches the software CRC-32 model over words 0..306, and dout_last is only on the trailer.
